// File: rtl/lc3_fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : lc3_fetch_prefetch
// Description : LC3 fetch stage with a prefetch FIFO. Issues instruction
//               memory reads, tags each read with its address, buffers the
//               returned words, and presents {instr, pc, npc} to decode over
//               valid/ready. A branch redirect clears the FIFO and discards
//               the reads that are still in flight when it arrives.
//               Optional macro LC3_FETCH_STATS_EN adds the stat_fetched and
//               stat_flushed counters.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_fetch_prefetch #(
  parameter int                ADDR_W    = 16,
  parameter int                INSTR_W   = 16,
  parameter int                DEPTH     = 4,
  parameter int                MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = 16'h3000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_fetch,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  taddr,
  output logic               imem_rd,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [INSTR_W-1:0] dout_instr,
  output logic [ADDR_W-1:0]  dout_pc,
  output logic [ADDR_W-1:0]  dout_npc
`ifdef LC3_FETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_flushed
`endif
);

  localparam int              PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CNT_W       = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]  DEPTH_C     = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_OUTST_C = CNT_W'(MAX_OUTST);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0]  pc;
  logic [CNT_W-1:0]   outst;
  logic [CNT_W-1:0]   drop_cnt, drop_cnt_nx;
  logic [CNT_W-1:0]   inflight_left;

  // Address tags of reads in flight, popped in order as responses return.
  logic [ADDR_W-1:0]  tag_q [DEPTH];
  logic [PTR_W-1:0]   tag_wr, tag_rd;

  // Prefetch FIFO storage.
  logic [INSTR_W-1:0] fifo_instr [DEPTH];
  logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
  logic [PTR_W-1:0]   fifo_wr, fifo_rd;
  logic [CNT_W-1:0]   fifo_count;

  logic               req_acc, rsp_take, rsp_drop, push, pop;
  logic [PTR_W-1:0]   rd_nx;
  logic [CNT_W-1:0]   remain;
  logic               head_valid_nx;
  logic [INSTR_W-1:0] head_instr_nx;
  logic [ADDR_W-1:0]  head_pc_nx;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_take      = imem_rvalid & (outst != '0);
  // Words landing on a redirect, or while stale reads remain, are discarded.
  assign rsp_drop      = rsp_take & (br_taken | (drop_cnt != '0));
  assign push          = rsp_take & ~rsp_drop;
  assign pop           = dout_valid & dout_ready;
  assign req_acc       = imem_rd & imem_ready;
  assign inflight_left = outst - CNT_W'(rsp_take);
  assign imem_addr     = pc;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      drop_cnt <= '0;
    end else begin
      state    <= state_nx;
      drop_cnt <= drop_cnt_nx;
    end
  end

  // Next-state, drop counter and read-request issue.
  always_comb begin
    state_nx    = state;
    drop_cnt_nx = drop_cnt;
    imem_rd     = 1'b0;
    case (state)
      FETCH: begin
        // Credit check keeps buffered plus in-flight words within the FIFO.
        imem_rd = ~reset & enable_fetch & ~br_taken & (outst < MAX_OUTST_C) &
                  (({1'b0, fifo_count} + {1'b0, outst}) < DEPTH_C);
        if (br_taken && inflight_left != '0) begin
          state_nx    = FLUSH;
          drop_cnt_nx = inflight_left;
        end
      end
      FLUSH: begin
        if (br_taken)
          drop_cnt_nx = inflight_left;
        else if (rsp_take && drop_cnt != '0)
          drop_cnt_nx = drop_cnt - CNT_W'(1);
        if (drop_cnt_nx == '0)
          state_nx = FETCH;
      end
      default: state_nx = FETCH;
    endcase
  end

  // Next FIFO head: surviving entry after a pop, else the word arriving now.
  always_comb begin
    rd_nx         = fifo_rd + PTR_W'(pop);
    remain        = fifo_count - CNT_W'(pop);
    head_valid_nx = 1'b0;
    head_instr_nx = '0;
    head_pc_nx    = '0;
    if (remain != '0) begin
      head_valid_nx = 1'b1;
      head_instr_nx = fifo_instr[rd_nx];
      head_pc_nx    = fifo_pc[rd_nx];
    end else if (push) begin
      head_valid_nx = 1'b1;
      head_instr_nx = imem_rdata;
      head_pc_nx    = tag_q[tag_rd];
    end
  end

  // PC, outstanding count, tag pointers, FIFO pointers and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      outst      <= '0;
      tag_wr     <= '0;
      tag_rd     <= '0;
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
      dout_valid <= 1'b0;
      dout_instr <= '0;
      dout_pc    <= '0;
      dout_npc   <= '0;
    end else begin
      if (br_taken)
        pc <= taddr;
      else if (req_acc)
        pc <= pc + ADDR_W'(1);

      case ({req_acc, rsp_take})
        2'b10:   outst <= outst + CNT_W'(1);
        2'b01:   outst <= outst - CNT_W'(1);
        default: outst <= outst;
      endcase

      if (req_acc)
        tag_wr <= tag_wr + PTR_W'(1);
      if (rsp_take)
        tag_rd <= tag_rd + PTR_W'(1);

      if (br_taken) begin
        fifo_wr    <= '0;
        fifo_rd    <= '0;
        fifo_count <= '0;
        dout_valid <= 1'b0;
        dout_instr <= '0;
        dout_pc    <= '0;
        dout_npc   <= '0;
      end else begin
        fifo_wr    <= fifo_wr + PTR_W'(push);
        fifo_rd    <= rd_nx;
        fifo_count <= remain + CNT_W'(push);
        dout_valid <= head_valid_nx;
        dout_instr <= head_instr_nx;
        dout_pc    <= head_pc_nx;
        dout_npc   <= head_valid_nx ? head_pc_nx + ADDR_W'(1) : '0;
      end
    end
  end

  // Storage arrays: only written slots are ever read, so no reset is needed.
  always_ff @(posedge clock) begin
    if (req_acc)
      tag_q[tag_wr] <= pc;
    if (push) begin
      fifo_instr[fifo_wr] <= imem_rdata;
      fifo_pc[fifo_wr]    <= tag_q[tag_rd];
    end
  end

`ifdef LC3_FETCH_STATS_EN
  logic [32:0] fetched_sum, flushed_sum;
  logic [31:0] flushed_inc;

  // Discarded responses plus FIFO entries wiped by a redirect (a popped head
  // was consumed, not flushed).
  always_comb begin
    flushed_inc = 32'(rsp_drop);
    if (br_taken)
      flushed_inc = flushed_inc + 32'(remain);
    fetched_sum = {1'b0, stat_fetched} + 33'(push);
    flushed_sum = {1'b0, stat_flushed} + {1'b0, flushed_inc};
  end

  // Saturating statistics counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      stat_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
      stat_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end
`endif

  // Responses arriving with nothing outstanding are a protocol error.
  stray_rvalid_c: cover property (@(posedge clock) disable iff (reset)
                                  (imem_rvalid && outst == '0));

endmodule
`default_nettype wire

// File: tb/tb_lc3_fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_fetch_prefetch
// Description : Scoreboard bench for lc3_fetch_prefetch. An imem responder
//               returns addr^5A5A one cycle after each accepted read; a
//               monitor checks every accepted read address and every word
//               handed to decode against queues filled by the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_fetch_prefetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_fetch = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] taddr = '0;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic [15:0] dout_instr, dout_pc, dout_npc;
`ifdef LC3_FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushed;
`endif

  lc3_fetch_prefetch #(
    .ADDR_W(16), .INSTR_W(16), .DEPTH(4), .MAX_OUTST(2), .RESET_PC(16'h3000)
  ) dut (
    .clock(clock), .reset(reset), .enable_fetch(enable_fetch),
    .br_taken(br_taken), .taddr(taddr),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_instr(dout_instr), .dout_pc(dout_pc), .dout_npc(dout_npc)
`ifdef LC3_FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] req_q[$];
  logic [15:0] out_q[$];
  logic [15:0] pend[$];
  int          acc_cnt = 0;
  bit          hold = 1'b0;
  bit          stray = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Responder, request side: record accepted reads.
  initial forever begin
    @(negedge clock);
    if (imem_rd && imem_ready) begin
      pend.push_back(imem_addr);
      acc_cnt++;
    end
  end

  // Responder, data side: one response per cycle, in order.
  initial forever begin
    logic [15:0] a;
    @(posedge clock);
    #2;
    if (stray) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 16'hDEAD;
    end else if (!hold && pend.size() != 0) begin
      a = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(a);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  // Monitor: compare every accepted read and every decode handoff.
  initial forever begin
    logic [15:0] e, n;
    @(negedge clock);
    if (imem_rd && imem_ready) begin
      if (req_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_req: got addr %h, required no request", imem_addr);
      end else begin
        e = req_q.pop_front();
        check("imem_addr", {16'h0, imem_addr}, {16'h0, e});
      end
    end
    if (dout_valid && dout_ready) begin
      if (out_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pop: got pc %h, required no output", dout_pc);
      end else begin
        e = out_q.pop_front();
        n = e + 16'd1;
        check("dout_pc",    {16'h0, dout_pc},    {16'h0, e});
        check("dout_instr", {16'h0, dout_instr}, {16'h0, mem_word(e)});
        check("dout_npc",   {16'h0, dout_npc},   {16'h0, n});
      end
    end
  end

  // Queue n consecutive reads starting at 'start', run until all are accepted.
  task automatic fetch_n(input logic [15:0] start, input int n, input bit deliver);
    int          target;
    logic [15:0] a;
    target = acc_cnt + n;
    a = start;
    for (int i = 0; i < n; i++) begin
      req_q.push_back(a);
      if (deliver) out_q.push_back(a);
      a = a + 16'd1;
    end
    step();
    enable_fetch = 1'b1;
    for (int k = 0; k < 60 && acc_cnt < target; k++) begin
      @(negedge clock);
      #1;
    end
    if (acc_cnt < target) check("fetch_timeout", acc_cnt, target);
    step();
    enable_fetch = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((out_q.size() != 0 || req_q.size() != 0 || pend.size() != 0) && k < 100) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (k >= 100) check("drain_timeout", out_q.size(), 0);
    repeat (3) @(negedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_rd"},    {31'h0, imem_rd},    32'h0);
    check({tag, "_dout_valid"}, {31'h0, dout_valid}, 32'h0);
    check({tag, "_dout_instr"}, {16'h0, dout_instr}, 32'h0);
    check({tag, "_dout_pc"},    {16'h0, dout_pc},    32'h0);
    check({tag, "_dout_npc"},   {16'h0, dout_npc},   32'h0);
    check({tag, "_imem_addr"},  {16'h0, imem_addr},  32'h3000);
`ifdef LC3_FETCH_STATS_EN
    check({tag, "_stat_fetched"}, stat_fetched, 32'h0);
    check({tag, "_stat_flushed"}, stat_flushed, 32'h0);
`endif
  endtask

  initial begin
    int base;
    // Reset with fetch enabled and a redirect pending: both must be ignored.
    reset = 1'b1; enable_fetch = 1'b1; br_taken = 1'b1; taddr = 16'h1234;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    step();
    reset = 1'b0; br_taken = 1'b0; enable_fetch = 1'b0;

    // Streaming at full rate.
    fetch_n(16'h3000, 6, 1'b1);
    wait_drain();

    // Backpressure: exactly DEPTH words buffered, then drained in order.
    dout_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) req_q.push_back(16'h3006 + 16'(i));
    base = acc_cnt;
    enable_fetch = 1'b1;
    repeat (10) step();
    @(negedge clock);
    check("bp_imem_rd",    {31'h0, imem_rd},    32'h0);
    check("bp_dout_valid", {31'h0, dout_valid}, 32'h1);
    check("bp_head_pc",    {16'h0, dout_pc},    32'h3006);
    check("bp_accepts",    acc_cnt - base,      32'd4);
    step();
    enable_fetch = 1'b0;
    for (int i = 0; i < 4; i++) out_q.push_back(16'h3006 + 16'(i));
    dout_ready = 1'b1;
    wait_drain();

    // Redirect with two reads in flight: both discarded.
    step();
    hold = 1'b1;
    fetch_n(16'h300A, 2, 1'b0);
    br_taken = 1'b1; taddr = 16'h4100;
    @(negedge clock);
    check("br_no_rd", {31'h0, imem_rd}, 32'h0);
    step();
    br_taken = 1'b0; hold = 1'b0; enable_fetch = 1'b1;
    @(negedge clock);
    check("flush_no_rd", {31'h0, imem_rd}, 32'h0);
    fetch_n(16'h4100, 3, 1'b1);
    wait_drain();

    // Redirect coinciding with a landing response and a pop.
    dout_ready = 1'b0;
    req_q.push_back(16'h4103); req_q.push_back(16'h4104); req_q.push_back(16'h4105);
    out_q.push_back(16'h4103);
    step(); enable_fetch = 1'b1;
    step();
    step(); hold = 1'b1;
    step(); hold = 1'b0; dout_ready = 1'b1; br_taken = 1'b1; taddr = 16'h4200;
    @(negedge clock);
    check("br_pop_no_rd",   {31'h0, imem_rd},    32'h0);
    check("br_pop_valid",   {31'h0, dout_valid}, 32'h1);
    step(); br_taken = 1'b0;
    @(negedge clock);
    check("br_fifo_cleared", {31'h0, dout_valid}, 32'h0);
    fetch_n(16'h4200, 2, 1'b1);
    wait_drain();

    // Address wrap at FFFF.
    step(); br_taken = 1'b1; taddr = 16'hFFFE;
    step(); br_taken = 1'b0;
    fetch_n(16'hFFFE, 3, 1'b1);
    wait_drain();
`ifdef LC3_FETCH_STATS_EN
    check("stat_fetched", stat_fetched, 32'd19);
    check("stat_flushed", stat_flushed, 32'd4);
`endif

    // Reset in the middle of a flush, then a stray response.
    step();
    hold = 1'b1;
    fetch_n(16'h0001, 2, 1'b0);
    br_taken = 1'b1; taddr = 16'h5000;
    step(); br_taken = 1'b0;
    step(); reset = 1'b1; pend.delete(); hold = 1'b0; enable_fetch = 1'b1;
    @(negedge clock);
    check_reset_outputs("midflush_reset");
    step(); reset = 1'b0; enable_fetch = 1'b0;
    step(); stray = 1'b1;
    step(); stray = 1'b0;
    repeat (3) step();
    @(negedge clock);
    check("stray_ignored", {31'h0, dout_valid}, 32'h0);
    fetch_n(16'h3000, 2, 1'b1);
    wait_drain();

    check("out_q_empty", out_q.size(), 32'd0);
    check("req_q_empty", req_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
